conv_3x3_weight_feeder: RTL and testbench

CONV_3X3_WEIGHT_FEEDER -- requirements
Module: conv_3x3_weight_feeder

---
 rtl/conv_3x3_weight_feeder.sv | 105 ++++++++++
 tb/tb_conv_3x3_weight_feeder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/conv_3x3_weight_feeder.sv
// conv_3x3_weight_feeder: streams KERNEL_SIZE-word weight groups from memory to a 3x3 line buffer on request.
// Optional WFEED_PRELOAD_EN: the first group is sent on start without waiting for load_weights.
module conv_3x3_weight_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int KERNEL_SIZE = 9,
  parameter int CHANNEL_NUM_IN = 512,
  parameter int CHANNEL_NUM_OUT = 1,
  parameter int ADDR_WIDTH = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic load_weights,
  output logic rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic valid_weight_out,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic busy,
  output logic done,
  output logic req_overflow
);
  localparam int GROUPS = CHANNEL_NUM_IN * CHANNEL_NUM_OUT;
  localparam int KW = KERNEL_SIZE > 1 ? $clog2(KERNEL_SIZE) : 1;
  localparam int GW = $clog2(GROUPS + 1);
  typedef enum logic [1:0] {IDLE, WAIT_REQ, SEND, DRAIN} state_t;
  state_t state;
  logic [KW-1:0] kcnt;
  logic [GW-1:0] gcnt;
  logic dcnt, pending, rd_en_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rd_en <= 1'b0;
      rd_addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      req_overflow <= 1'b0;
      pending <= 1'b0;
      kcnt <= '0;
      gcnt <= '0;
      dcnt <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          rd_addr <= '0;
          gcnt <= '0;
          kcnt <= '0;
          pending <= 1'b0;
          req_overflow <= 1'b0;
          busy <= 1'b1;
`ifdef WFEED_PRELOAD_EN
          state <= SEND;
          rd_en <= 1'b1;
`else
          state <= WAIT_REQ;
`endif
        end
        WAIT_REQ: begin
          // a request arriving while a pending one is consumed is kept for the next group
          pending <= pending & load_weights;
          if (load_weights || pending) begin
            state <= SEND;
            rd_en <= 1'b1;
            kcnt <= '0;
          end
        end
        SEND: begin
          rd_addr <= rd_addr + 1'b1;
          kcnt <= kcnt + 1'b1;
          if (kcnt == KW'(KERNEL_SIZE - 1)) begin
            rd_en <= 1'b0;
            gcnt <= gcnt + 1'b1;
            dcnt <= 1'b0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          dcnt <= 1'b1;
          if (dcnt) begin
            state <= gcnt == GW'(GROUPS) ? IDLE : WAIT_REQ;
            done <= gcnt == GW'(GROUPS);
            busy <= gcnt != GW'(GROUPS);
          end
        end
      endcase
      if (load_weights && (state == SEND || state == DRAIN)) begin
        if (pending) req_overflow <= 1'b1;
        else pending <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en_d <= 1'b0;
      valid_weight_out <= 1'b0;
      weight_out <= '0;
    end else begin
      rd_en_d <= rd_en;
      valid_weight_out <= rd_en_d;
      if (rd_en_d) weight_out <= rd_data;
    end
  end
endmodule

// File: tb/tb_conv_3x3_weight_feeder.sv
// tb_conv_3x3_weight_feeder: directed checks of request handling, timing, overflow and reset; memory word[a]=a+100.
module tb_conv_3x3_weight_feeder;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, load_weights = 1'b0;
  logic rd_en, valid_weight_out, busy, done, req_overflow;
  logic [12:0] rd_addr;
  logic [31:0] rd_data = '0, weight_out;
  logic [31:0] q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  conv_3x3_weight_feeder #(.DATA_WIDTH(32), .KERNEL_SIZE(9), .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(1), .ADDR_WIDTH(13)) dut (
    .clk(clk), .reset(reset), .start(start), .load_weights(load_weights), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .valid_weight_out(valid_weight_out), .weight_out(weight_out), .busy(busy),
    .done(done), .req_overflow(req_overflow));
  always @(posedge clk) if (rd_en) rd_data <= 32'(rd_addr) + 32'd100;
  always @(posedge clk) begin
    #1;
    if (valid_weight_out) q.push_back(weight_out);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
    chk({tag, "_valid"}, 32'(valid_weight_out), 0);
    chk({tag, "_weight"}, weight_out, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ovf"}, 32'(req_overflow), 0);
  endtask
  task automatic start_pass();
    start = 1'b1;
    step();
    start = 1'b0;
`ifndef WFEED_PRELOAD_EN
    load_weights = 1'b1;
    step();
    load_weights = 1'b0;
`endif
  endtask
  task automatic send_group(input int base);
    for (int i = 0; i < 9; i++) begin
      chk("send_rd_en", 32'(rd_en), 1);
      chk("send_rd_addr", 32'(rd_addr), 32'(base + i));
      step();
    end
    chk("send_end_rd_en", 32'(rd_en), 0);
  endtask
  task automatic chk_q(input int n);
    chk("word_count", 32'(q.size()), 32'(n));
    for (int i = 0; i < n && i < q.size(); i++) chk("weight_word", q[i], 32'(100 + i));
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 60) begin
      step();
      n++;
    end
    chk("done_seen", 32'(done), 1);
  endtask
  initial begin
    step();
    step();
    all_zero("reset");
    reset = 1'b0;
    step();
`ifndef WFEED_PRELOAD_EN
    load_weights = 1'b1;
    step();
    load_weights = 1'b0;
    chk("idle_ignore_busy", 32'(busy), 0);
    chk("idle_ignore_rd_en", 32'(rd_en), 0);
`endif
    q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
`ifndef WFEED_PRELOAD_EN
    step();
    step();
    chk("wait_req_rd_en", 32'(rd_en), 0);
    load_weights = 1'b1;
    step();
    load_weights = 1'b0;
`endif
    send_group(0);
    step();
    step();
    chk_q(9);
    chk("hold_weight", weight_out, 108);
    chk("hold_valid", 32'(valid_weight_out), 0);
    chk("between_busy", 32'(busy), 1);
    chk("between_done", 32'(done), 0);
    load_weights = 1'b1;
    step();
    load_weights = 1'b0;
    send_group(9);
    step();
    step();
    chk("done_pulse", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    step();
    chk("done_clear", 32'(done), 0);
    chk_q(18);
    chk("no_ovf", 32'(req_overflow), 0);
    q.delete();
    start_pass();
    step();
    step();
    load_weights = 1'b1;
    step();
    load_weights = 1'b0;
    repeat (9) step();
    chk("pend_rd_en", 32'(rd_en), 1);
    chk("pend_rd_addr", 32'(rd_addr), 9);
    wait_done();
    chk("pend_ovf", 32'(req_overflow), 0);
    step();
    chk_q(18);
    q.delete();
    start_pass();
    step();
    load_weights = 1'b1;
    step();
    step();
    load_weights = 1'b0;
    step();
    chk("ovf_set", 32'(req_overflow), 1);
    wait_done();
    chk("ovf_at_done", 32'(req_overflow), 1);
    step();
    chk("ovf_sticky", 32'(req_overflow), 1);
    chk_q(18);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ovf_cleared", 32'(req_overflow), 0);
`ifndef WFEED_PRELOAD_EN
    load_weights = 1'b1;
    step();
    load_weights = 1'b0;
`endif
    repeat (3) step();
    chk("mid_rd_addr", 32'(rd_addr), 3);
    reset = 1'b1;
    #1;
    q.delete();
    all_zero("async_reset");
    step();
    reset = 1'b0;
    repeat (12) step();
    chk("post_reset_valid", 32'(q.size()), 0);
    chk("post_reset_busy", 32'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
